// File: rtl/spi_master_core.sv
// spi_master_core: SPI mode-0 master for a single transfer of 1..32 bits.
//
// Ports
//   PCLK       system clock, all state advances on its rising edge
//   PRESETn    asynchronous active-low reset
//   start      single-cycle transfer request (honoured only while idle)
//   tx_data    transmit word, right-aligned
//   char_len   transfer length in bits, 0 means 32
//   divider    SCLK half-period is (divider+1) PCLK cycles
//   ss_sel     slave-select mask, 1 selects that slave
//   lsb_first  1 = LSB first, 0 = MSB first
//   sclk       SPI clock (idles low)
//   cs_n       active-low chip selects, asserted only while shifting
//   mosi       serial data out, changes on sclk falling edges
//   miso       serial data in, sampled on sclk rising edges
//   rx_data    received word, right-aligned, updated once per transfer
//   busy       high from the cycle after start through the DONE cycle
//   done       single-cycle completion pulse
module spi_master_core (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        start,
  input  logic [31:0] tx_data,
  input  logic [4:0]  char_len,
  input  logic [7:0]  divider,
  input  logic [7:0]  ss_sel,
  input  logic        lsb_first,
  output logic        sclk,
  output logic [7:0]  cs_n,
  output logic        mosi,
  input  logic        miso,
  output logic [31:0] rx_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q;
  logic [7:0]  cnt_q;
  logic [5:0]  len_q;
  logic [5:0]  bit_q;
  logic [7:0]  ss_q;
  logic        lsb_q;
  logic [31:0] tx_q;
  logic [31:0] rx_q;

  logic [5:0]  len_d;
  logic        half_tick;
  logic        rise;
  logic        fall;
  logic        last_fall;

  assign len_d     = (char_len == 5'd0) ? 6'd32 : {1'b0, char_len};
  assign half_tick = (state_q == ACTIVE) && (cnt_q == div_q);
  assign rise      = half_tick && !sclk;
  assign fall      = half_tick && sclk;
  assign last_fall = fall && (bit_q == (len_q - 6'd1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    cs_n    = '1;
    mosi    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = ACTIVE;
      end
      ACTIVE: begin
        busy = 1'b1;
        cs_n = ~ss_q;
        mosi = lsb_q ? tx_q[0] : tx_q[31];
        if (last_fall) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // MSB-first words are left-aligned at capture so the outgoing bit is always
  // tx_q[31]; LSB-first words stay right-aligned and shift out of tx_q[0].
  // LSB-first reception fills from bit 31 downward and is right-aligned when
  // the result is published.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sclk    <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      len_q   <= '0;
      ss_q    <= '0;
      lsb_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rx_data <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          sclk  <= 1'b0;
          cnt_q <= '0;
          bit_q <= '0;
          if (start) begin
            len_q <= len_d;
            div_q <= divider;
            ss_q  <= ss_sel;
            lsb_q <= lsb_first;
            tx_q  <= lsb_first ? tx_data : (tx_data << (6'd32 - len_d));
            rx_q  <= '0;
          end
        end
        ACTIVE: begin
          if (half_tick) begin
            cnt_q <= '0;
            sclk  <= ~sclk;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
          if (rise) begin
            rx_q <= lsb_q ? {miso, rx_q[31:1]} : {rx_q[30:0], miso};
          end
          if (fall) begin
            bit_q <= bit_q + 6'd1;
            if (last_fall) begin
              rx_data <= lsb_q ? (rx_q >> (6'd32 - len_q)) : rx_q;
            end else begin
              tx_q <= lsb_q ? (tx_q >> 1) : (tx_q << 1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
module tb_spi_master_core;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        start;
  logic [31:0] tx_data;
  logic [4:0]  char_len;
  logic [7:0]  divider;
  logic [7:0]  ss_sel;
  logic        lsb_first;
  logic        sclk;
  logic [7:0]  cs_n;
  logic        mosi;
  logic        miso;
  logic [31:0] rx_data;
  logic        busy;
  logic        done;

  logic        loop_en;
  logic        miso_val;
  assign miso = loop_en ? mosi : miso_val;

  spi_master_core dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .start     (start),
    .tx_data   (tx_data),
    .char_len  (char_len),
    .divider   (divider),
    .ss_sel    (ss_sel),
    .lsb_first (lsb_first),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .rx_data   (rx_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 PCLK = ~PCLK;

  int unsigned cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rx;
    int unsigned lat;
    logic [31:0] seq;
    int unsigned toggles;
    logic [7:0]  cs;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [31:0] tx, input logic [4:0] cl,
                                 input logic [7:0] div, input logic [7:0] ss,
                                 input bit lsb, input bit loop, input bit mv);
    exp_t e;
    int unsigned len;
    logic [31:0] mask;
    len  = (cl == 5'd0) ? 32 : int'(cl);
    mask = (len == 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
    e.seq = '0;
    for (int k = 0; k < int'(len); k++) begin
      e.seq = {e.seq[30:0], lsb ? tx[k] : tx[int'(len) - 1 - k]};
    end
    e.rx      = loop ? (tx & mask) : (mv ? mask : 32'h0);
    e.lat     = 1 + 2 * len * (int'(div) + 1);
    e.toggles = 2 * len;
    e.cs      = ~ss;
    return e;
  endfunction

  task automatic run_xfer(input logic [31:0] tx, input logic [4:0] cl, input logic [7:0] div,
                          input logic [7:0] ss, input bit lsb, input bit loop, input bit mv,
                          input bit poke);
    exp_t e, g;
    int unsigned t0, tog, budget, extra;
    logic [31:0] seq, rx0;
    bit cs_ok, rx_ok, seen, prev;
    @(negedge PCLK);
    tx_data = tx; char_len = cl; divider = div; ss_sel = ss; lsb_first = lsb;
    loop_en = loop; miso_val = mv; start = 1'b1;
    t0 = cyc;
    e = model(tx, cl, div, ss, lsb, loop, mv);
    sb.push_back(e);
    budget = e.lat + 20;
    @(negedge PCLK);
    start = 1'b0;
    // config is don't-care after capture
    tx_data = $urandom; char_len = 5'($urandom); divider = 8'($urandom);
    ss_sel = 8'($urandom); lsb_first = 1'($urandom);
    tog = 0; seq = '0; cs_ok = 1; rx_ok = 1; seen = 0; prev = 1'b0; rx0 = rx_data;
    for (int i = 0; i < int'(budget); i++) begin
      if (i > 0) @(negedge PCLK);
      if (poke) start = (cyc == t0 + 5);
      if (sclk !== prev) begin
        tog++;
        if (sclk === 1'b1) seq = {seq[30:0], mosi};
        prev = sclk;
      end
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (cs_n !== e.cs || busy !== 1'b1) cs_ok = 0;
      if (rx_data !== rx0) rx_ok = 0;
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
      start = 1'b0;
      return;
    end
    g = sb.pop_front();
    chk("done_latency", 32'(cyc - t0), 32'(g.lat));
    chk("rx_data", rx_data, g.rx);
    chk("mosi_seq", seq, g.seq);
    chk("sclk_toggles", 32'(tog), 32'(g.toggles));
    chk("cs_active", 32'(cs_ok), 32'd1);
    chk("rx_hold", 32'(rx_ok), 32'd1);
    chk("done_state", {sclk, mosi, busy, cs_n}, {1'b0, 1'b0, 1'b1, 8'hFF});
    if (poke) start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    chk("idle_after", {busy, done, cs_n}, {1'b0, 1'b0, 8'hFF});
    if (poke) begin
      extra = 0;
      for (int i = 0; i < int'(budget); i++) begin
        @(negedge PCLK);
        if (done === 1'b1 || busy === 1'b1) extra++;
      end
      chk("ignored_start", 32'(extra), 32'd0);
    end
  endtask

  task automatic reset_outputs(input string tag);
    chk(tag, {sclk, cs_n, mosi, busy, done}, {1'b0, 8'hFF, 1'b0, 1'b0, 1'b0});
    chk({tag, "_rx"}, rx_data, 32'h0);
  endtask

  task automatic abort_xfer();
    int unsigned t0, ndone;
    @(negedge PCLK);
    tx_data = 32'h3C; char_len = 5'd8; divider = 8'd1; ss_sel = 8'h04; lsb_first = 1'b0;
    loop_en = 1'b1; start = 1'b1;
    t0 = cyc;
    @(negedge PCLK);
    start = 1'b0;
    while (cyc < t0 + 6) @(negedge PCLK);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    PRESETn = 1'b0;
    #1;
    reset_outputs("abort_reset");
    @(negedge PCLK);
    PRESETn = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    PRESETn = 1'b0; start = 1'b0; tx_data = '0; char_len = '0; divider = '0;
    ss_sel = '0; lsb_first = 1'b0; loop_en = 1'b1; miso_val = 1'b0;
    repeat (3) @(negedge PCLK);
    reset_outputs("reset");
    PRESETn = 1'b1;
    @(negedge PCLK);
    reset_outputs("post_release");

    run_xfer(32'h0000_00A5, 5'd8, 8'd0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    run_xfer(32'h0000_0001, 5'd4, 8'd3, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0);
    run_xfer(32'hDEAD_BEEF, 5'd0, 8'd0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    run_xfer(32'h0000_005A, 5'd8, 8'd0, 8'h10, 1'b0, 1'b1, 1'b0, 1'b1);
    abort_xfer();
    run_xfer(32'h0000_0123, 5'd12, 8'd1, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0);
    run_xfer(32'h0000_00C3, 5'd8, 8'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    run_xfer(32'hFFFF_FFFF, 5'd1, 8'd2, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      run_xfer($urandom, 5'($urandom), 8'($urandom_range(0, 2)), 8'($urandom),
               1'($urandom), 1'b1, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
